// File: rtl/ofdm_fft_ctrl.sv
// ============================================================================
// Module      : ofdm_fft_ctrl
// Description : Frame sequencer and output framing monitor around the
//               streaming FFT/IFFT core of the OFDM chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ofdm_fft_ctrl #(
    parameter int FFT_N        = 64,
    parameter int LOG2N        = 6,
    parameter int DW           = 8,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_inverse,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          fft_sink_valid,
    input  logic          fft_sink_ready,
    output logic          fft_sink_sop,
    output logic          fft_sink_eop,
    output logic [DW-1:0] fft_sink_real,
    output logic [DW-1:0] fft_sink_imag,
    output logic [1:0]    fft_sink_error,
    output logic          fft_inverse,
    input  logic          fft_src_valid,
    output logic          fft_src_ready,
    input  logic          fft_src_sop,
    input  logic          fft_src_eop,
    input  logic [1:0]    fft_src_error,
    input  logic [DW-1:0] fft_src_real,
    input  logic [DW-1:0] fft_src_imag,
    input  logic [5:0]    fft_src_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_sop,
    output logic          out_eop,
    output logic [5:0]    out_exp,
    output logic          frame_err,
    output logic [15:0]   frames_in,
    output logic [15:0]   frames_out,
    output logic          busy
);

    localparam logic [0:0]       c_ST_IDLE      = 1'b0;
    localparam logic [0:0]       c_ST_STREAM    = 1'b1;
    localparam logic [LOG2N-1:0] c_LAST         = LOG2N'(FFT_N - 1);
    localparam logic [2:0]       c_MAX_INFLIGHT = 3'(MAX_INFLIGHT);

    logic [0:0]       r_state;
    logic [LOG2N-1:0] r_in_cnt;
    logic [LOG2N-1:0] r_out_cnt;
    logic [2:0]       r_in_flight;
    logic             r_cur_inverse;
    logic [15:0]      r_frames_in;
    logic [15:0]      r_frames_out;
    logic             r_frame_err;

    logic w_admit;
    logic w_gate;
    logic w_sink_acc;
    logic w_in_last;
    logic w_src_acc;
    logic w_viol;
    logic w_in_done;
    logic w_out_done;

    // Admission only matters at a frame boundary; mid-frame the gate is open.
    assign w_admit    = (cfg_inverse == r_cur_inverse) && (r_in_flight < c_MAX_INFLIGHT);
    assign w_gate     = (r_state == c_ST_STREAM) || w_admit;
    assign w_sink_acc = fft_sink_valid & fft_sink_ready;
    assign w_in_last  = (r_in_cnt == c_LAST);
    assign w_in_done  = w_sink_acc & w_in_last;
    assign w_src_acc  = fft_src_valid & out_ready;
    assign w_out_done = w_src_acc & fft_src_eop;

    assign w_viol = (fft_src_sop != (r_out_cnt == '0))
                 || (fft_src_eop != (r_out_cnt == c_LAST))
                 || (fft_src_error != 2'b00)
                 || (fft_src_eop && (r_in_flight == 3'd0));

    assign fft_sink_valid = in_valid & w_gate;
    assign in_ready       = fft_sink_ready & w_gate;
    assign fft_sink_sop   = (r_in_cnt == '0);
    assign fft_sink_eop   = w_in_last;
    assign fft_sink_real  = in_real;
    assign fft_sink_imag  = in_imag;
    assign fft_sink_error = 2'b00;
    assign fft_inverse    = r_cur_inverse;

    assign out_valid     = fft_src_valid;
    assign fft_src_ready = out_ready;
    assign out_real      = fft_src_real;
    assign out_imag      = fft_src_imag;
    assign out_sop       = fft_src_sop;
    assign out_eop       = fft_src_eop;
    assign out_exp       = fft_src_exp;

    assign frame_err  = r_frame_err;
    assign frames_in  = r_frames_in;
    assign frames_out = r_frames_out;
    assign busy       = (r_state == c_ST_STREAM) || (r_in_flight != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_in_cnt      <= '0;
            r_frames_in   <= 16'd0;
            r_cur_inverse <= 1'b0;
        end else begin
            if (w_sink_acc) begin
                if (w_in_last) begin
                    r_in_cnt    <= '0;
                    r_state     <= c_ST_IDLE;
                    r_frames_in <= r_frames_in + 16'd1;
                end else begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                    r_state  <= c_ST_STREAM;
                end
            end
            // Transform select may only move with the core fully drained.
            if ((r_state == c_ST_IDLE) && (r_in_flight == 3'd0)) begin
                r_cur_inverse <= cfg_inverse;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_flight <= 3'd0;
        end else begin
            case ({w_in_done, w_out_done})
                2'b10:   r_in_flight <= r_in_flight + 3'd1;
                2'b01:   if (r_in_flight != 3'd0) r_in_flight <= r_in_flight - 3'd1;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_cnt    <= '0;
            r_frames_out <= 16'd0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_src_acc & w_viol;
            if (w_src_acc) begin
                // A sop always resynchronises the output beat counter.
                if (fft_src_sop) begin
                    r_out_cnt <= LOG2N'(1);
                end else if (fft_src_eop) begin
                    r_out_cnt <= '0;
                end else begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
                if (fft_src_eop) begin
                    r_frames_out <= r_frames_out + 16'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ofdm_fft_ctrl.sv
// ============================================================================
// Module      : tb_ofdm_fft_ctrl
// Description : Randomised bench for ofdm_fft_ctrl with a frame-level model
//               of the controller and a simple stand-in for the FFT core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ofdm_fft_ctrl;

    localparam int FFT_N        = 64;
    localparam int LOG2N        = 6;
    localparam int DW           = 8;
    localparam int MAX_INFLIGHT = 2;
    localparam int NCYC         = 4000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_inverse;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_real, in_imag;
    logic          fft_sink_valid, fft_sink_ready, fft_sink_sop, fft_sink_eop;
    logic [DW-1:0] fft_sink_real, fft_sink_imag;
    logic [1:0]    fft_sink_error;
    logic          fft_inverse;
    logic          fft_src_valid, fft_src_ready, fft_src_sop, fft_src_eop;
    logic [1:0]    fft_src_error;
    logic [DW-1:0] fft_src_real, fft_src_imag;
    logic [5:0]    fft_src_exp;
    logic          out_valid, out_ready, out_sop, out_eop;
    logic [DW-1:0] out_real, out_imag;
    logic [5:0]    out_exp;
    logic          frame_err;
    logic [15:0]   frames_in, frames_out;
    logic          busy;

    always #5 clk = ~clk;

    ofdm_fft_ctrl #(
        .FFT_N(FFT_N), .LOG2N(LOG2N), .DW(DW), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk), .reset(reset), .cfg_inverse(cfg_inverse),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
        .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
        .fft_sink_real(fft_sink_real), .fft_sink_imag(fft_sink_imag),
        .fft_sink_error(fft_sink_error), .fft_inverse(fft_inverse),
        .fft_src_valid(fft_src_valid), .fft_src_ready(fft_src_ready),
        .fft_src_sop(fft_src_sop), .fft_src_eop(fft_src_eop),
        .fft_src_error(fft_src_error), .fft_src_real(fft_src_real),
        .fft_src_imag(fft_src_imag), .fft_src_exp(fft_src_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_sop(out_sop), .out_eop(out_eop), .out_exp(out_exp),
        .frame_err(frame_err), .frames_in(frames_in), .frames_out(frames_out),
        .busy(busy)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Controller model: beats taken in the current frame, frames inside the core.
    int m_in_idx, m_out_idx, m_inflight, m_frames_in, m_frames_out;
    bit m_cur_inv, m_err, m_frame_inv;

    // Core stand-in: frames queued in order, emitted with optional defects.
    bit q_inv[$];
    bit e_active, e_inv;
    int e_pos, e_len, e_err_beat;

    task automatic model_reset();
        m_in_idx = 0; m_out_idx = 0; m_inflight = 0;
        m_frames_in = 0; m_frames_out = 0;
        m_cur_inv = 0; m_err = 0; m_frame_inv = 0;
        q_inv.delete();
        e_active = 0; e_pos = 0; e_len = FFT_N; e_err_beat = -1;
    endtask

    // Called at posedge+1; returns at posedge+1 with reset released.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        in_valid = 1'b0;
        fft_src_valid = 1'b0;
        fft_src_sop = 1'b0;
        fft_src_eop = 1'b0;
        fft_src_error = 2'b00;
        #4;
        model_reset();
        check_eq({tag, "_frames_in"}, frames_in, 0);
        check_eq({tag, "_frames_out"}, frames_out, 0);
        check_eq({tag, "_fft_inverse"}, fft_inverse, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_frame_err"}, frame_err, 0);
        check_eq({tag, "_sink_sop"}, fft_sink_sop, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive_inputs(input int cyc);
        int r;
        if ($urandom_range(0, 99) == 0) cfg_inverse = ~cfg_inverse;
        in_valid = ($urandom_range(0, 99) < 85);
        in_real  = DW'($urandom);
        in_imag  = DW'($urandom);
        if ((cyc % 200) < 40) fft_sink_ready = cyc[0];
        else                  fft_sink_ready = ($urandom_range(0, 99) < 80);
        if ((cyc % 500) < 200) out_ready = 1'b0;
        else                   out_ready = ($urandom_range(0, 99) < 80);

        if (!e_active && (q_inv.size() > 0)) begin
            e_inv = q_inv.pop_front();
            e_active = 1'b1;
            e_pos = 0;
            r = $urandom_range(0, 9);
            e_len = (r == 0) ? 32 : FFT_N;
            e_err_beat = (r == 1) ? $urandom_range(0, FFT_N - 1) : -1;
        end
        fft_src_valid = e_active && ($urandom_range(0, 99) < 85);
        fft_src_sop   = e_active && (e_pos == 0);
        fft_src_eop   = e_active && (e_pos == e_len - 1);
        fft_src_error = (e_active && (e_pos == e_err_beat)) ? 2'($urandom_range(1, 3)) : 2'b00;
        fft_src_real  = DW'($urandom);
        fft_src_imag  = DW'($urandom);
        fft_src_exp   = 6'($urandom);
    endtask

    task automatic check_and_step();
        bit p_gate, sink_acc, src_acc, in_done, out_done, idle_drained, viol;
        p_gate = (m_in_idx != 0) || ((cfg_inverse == m_cur_inv) && (m_inflight < MAX_INFLIGHT));

        check_eq("in_ready", in_ready, fft_sink_ready && p_gate);
        check_eq("sink_valid", fft_sink_valid, in_valid && p_gate);
        check_eq("sink_sop", fft_sink_sop, m_in_idx == 0);
        check_eq("sink_eop", fft_sink_eop, m_in_idx == FFT_N - 1);
        check_eq("sink_data", {fft_sink_real, fft_sink_imag}, {in_real, in_imag});
        check_eq("sink_error", fft_sink_error, 0);
        check_eq("out_valid", out_valid, fft_src_valid);
        check_eq("src_ready", fft_src_ready, out_ready);
        check_eq("out_data", {out_real, out_imag, out_exp, out_sop, out_eop},
                 {fft_src_real, fft_src_imag, fft_src_exp, fft_src_sop, fft_src_eop});
        check_eq("fft_inverse", fft_inverse, m_cur_inv);
        check_eq("frames_in", frames_in, m_frames_in);
        check_eq("frames_out", frames_out, m_frames_out);
        check_eq("busy", busy, (m_in_idx != 0) || (m_inflight != 0));
        check_eq("frame_err", frame_err, m_err);

        idle_drained = (m_in_idx == 0) && (m_inflight == 0);
        sink_acc = in_valid && p_gate && fft_sink_ready;
        src_acc  = fft_src_valid && out_ready;
        in_done  = 0;
        out_done = 0;
        viol     = 0;

        if (sink_acc) begin
            if (m_in_idx == 0) m_frame_inv = m_cur_inv;
            m_in_idx++;
            if (m_in_idx == FFT_N) begin
                m_in_idx = 0;
                m_frames_in = (m_frames_in + 1) % 65536;
                in_done = 1;
                q_inv.push_back(m_frame_inv);
            end
        end

        if (src_acc) begin
            viol = (fft_src_sop != (m_out_idx == 0))
                || (fft_src_eop != (m_out_idx == FFT_N - 1))
                || (fft_src_error != 2'b00)
                || (fft_src_eop && (m_inflight == 0));
            if (fft_src_sop)      m_out_idx = 1;
            else if (fft_src_eop) m_out_idx = 0;
            else                  m_out_idx = (m_out_idx + 1) % FFT_N;
            if (fft_src_eop) begin
                m_frames_out = (m_frames_out + 1) % 65536;
                out_done = 1;
                check_eq("src_frame_inverse", fft_inverse, e_inv);
            end
            e_pos++;
            if (e_pos == e_len) e_active = 0;
        end
        m_err = src_acc && viol;

        if (in_done && !out_done) m_inflight++;
        else if (out_done && !in_done && (m_inflight > 0)) m_inflight--;

        if (idle_drained) m_cur_inv = cfg_inverse;
    endtask

    initial begin
        bit did_mid_reset;
        did_mid_reset = 0;
        cfg_inverse = 1'b0;
        in_real = '0; in_imag = '0;
        fft_sink_ready = 1'b1;
        out_ready = 1'b1;
        fft_src_real = '0; fft_src_imag = '0; fft_src_exp = '0;
        #1;
        do_reset("rst");

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (!did_mid_reset && (cyc > 1500) && ((m_in_idx == 20) || (cyc > 2500))) begin
                did_mid_reset = 1;
                do_reset("midrst");
            end else begin
                drive_inputs(cyc);
                #4;
                check_and_step();
                @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

`default_nettype wire
